// File: rtl/vrf_pkg.sv
// Shared types and helpers for the vector register-file issue sequencer.
package vrf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } vrf_seq_state_e;

    // Upper bound on lanes handled by lane_mask; callers slice the low lanes_p bits.
    localparam int unsigned MAX_LANES = 32;

    // Width helper that never returns 0, so a single-entry range still gets a 1-bit select.
    function automatic int safe_clog2(input int x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

    // Lane i of a beat is active when its element index beat*lanes+i lies below vl.
    function automatic logic [MAX_LANES-1:0] lane_mask(input int unsigned beat,
                                                       input int unsigned vl,
                                                       input int unsigned lanes);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (i < lanes) begin
                m[i] = ((beat * lanes + i) < vl);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/vrf_beat_addr_gen.sv
// Beat counter with per-lane element index and active-lane mask generation.
module vrf_beat_addr_gen
    import vrf_pkg::*;
#(
    parameter int lanes_p = 4,
    parameter int vlen_p  = 8,
    localparam int beats_lp            = vlen_p / lanes_p,
    localparam int beat_width_lp       = safe_clog2(beats_lp + 1),
    localparam int local_addr_width_lp = safe_clog2(vlen_p),
    localparam int vl_width_lp         = safe_clog2(vlen_p + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   clear_i,
    input  logic                                   inc_i,
    input  logic [vl_width_lp-1:0]                 vl_i,
    output logic [beat_width_lp-1:0]               beat_o,
    output logic [lanes_p*local_addr_width_lp-1:0] addr_o,
    output logic [lanes_p-1:0]                     mask_o
);

    // The counter can reach beats_lp (one past the last beat) so the issue and
    // writeback counters never alias when compared.
    logic [beat_width_lp-1:0] beat_q;

    // Beat counter: cleared when a new instruction is accepted, advanced per handshake.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            beat_q <= '0;
        end else if (clear_i) begin
            beat_q <= '0;
        end else if (inc_i) begin
            beat_q <= beat_q + beat_width_lp'(1);
        end
    end

    assign beat_o = beat_q;
    assign mask_o = lanes_p'(lane_mask(32'(beat_q), 32'(vl_i), lanes_p));

    // Element index for each lane of the current beat.
    always_comb begin
        addr_o = '0;
        for (int i = 0; i < lanes_p; i++) begin
            addr_o[i*local_addr_width_lp +: local_addr_width_lp] =
                local_addr_width_lp'(int'(beat_q) * lanes_p + i);
        end
    end

endmodule

// File: rtl/vrf_issue_seq.sv
// Sequences one vector instruction: reads operands beat by beat, hands them to
// the lanes, and writes in-order lane results back to the register file.
module vrf_issue_seq
    import vrf_pkg::*;
#(
    parameter int els_p   = 32,
    parameter int vlen_p  = 8,
    parameter int vdw_p   = 32,
    parameter int lanes_p = 4,
    localparam int beats_lp            = vlen_p / lanes_p,
    localparam int beat_width_lp       = safe_clog2(beats_lp + 1),
    localparam int v_addr_width_lp     = safe_clog2(els_p),
    localparam int local_addr_width_lp = safe_clog2(vlen_p),
    localparam int vl_width_lp         = safe_clog2(vlen_p + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   instr_v_i,
    output logic                                   instr_ready_o,
    input  logic [v_addr_width_lp-1:0]             instr_vd_i,
    input  logic [v_addr_width_lp-1:0]             instr_vs1_i,
    input  logic [v_addr_width_lp-1:0]             instr_vs2_i,
    input  logic [vl_width_lp-1:0]                 instr_vl_i,
    output logic [v_addr_width_lp-1:0]             r_reg0_addr_o,
    output logic [v_addr_width_lp-1:0]             r_reg1_addr_o,
    output logic [lanes_p*local_addr_width_lp-1:0] r_addr_o,
    input  logic [lanes_p*vdw_p-1:0]               r0_data_i,
    input  logic [lanes_p*vdw_p-1:0]               r1_data_i,
    output logic                                   op_v_o,
    input  logic                                   op_ready_i,
    output logic [lanes_p*vdw_p-1:0]               op_a_o,
    output logic [lanes_p*vdw_p-1:0]               op_b_o,
    output logic [lanes_p-1:0]                     op_mask_o,
    input  logic                                   res_v_i,
    input  logic [lanes_p*vdw_p-1:0]               res_data_i,
    output logic [v_addr_width_lp-1:0]             w_reg_addr_o,
    output logic [lanes_p*local_addr_width_lp-1:0] w_addr_o,
    output logic [lanes_p*vdw_p-1:0]               w_data_o,
    output logic [lanes_p-1:0]                     w_en_o,
    output logic                                   busy_o,
    output logic                                   done_o
);

    vrf_seq_state_e             state_q;
    logic [v_addr_width_lp-1:0] vd_q, vs1_q, vs2_q;
    logic [vl_width_lp-1:0]     vl_q;

    logic                       accept;
    logic                       issue_fire;
    logic                       wb_fire;
    logic                       issue_last;
    logic                       wb_last;
    logic [beat_width_lp-1:0]   nbeats_m1;
    logic [beat_width_lp-1:0]   issue_beat;
    logic [beat_width_lp-1:0]   wb_beat;
    logic [lanes_p-1:0]         wb_mask;

    // Index of the final beat; meaningless for vl=0, which never leaves for ISSUE.
    assign nbeats_m1  = beat_width_lp'((32'(vl_q) + lanes_p - 1) / lanes_p - 1);

    assign accept     = instr_v_i && (state_q == IDLE);
    assign issue_fire = (state_q == ISSUE) && op_ready_i;
    // A result is only meaningful for a beat that has already been issued;
    // anything else (idle, finishing, or ahead of issue) is dropped.
    assign wb_fire    = res_v_i && ((state_q == ISSUE) || (state_q == DRAIN))
                        && (wb_beat != issue_beat);
    assign issue_last = (issue_beat == nbeats_m1);
    assign wb_last    = (wb_beat == nbeats_m1);

    vrf_beat_addr_gen #(
        .lanes_p (lanes_p),
        .vlen_p  (vlen_p)
    ) issue_gen (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (accept),
        .inc_i     (issue_fire),
        .vl_i      (vl_q),
        .beat_o    (issue_beat),
        .addr_o    (r_addr_o),
        .mask_o    (op_mask_o)
    );

    vrf_beat_addr_gen #(
        .lanes_p (lanes_p),
        .vlen_p  (vlen_p)
    ) wb_gen (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (accept),
        .inc_i     (wb_fire),
        .vl_i      (vl_q),
        .beat_o    (wb_beat),
        .addr_o    (w_addr_o),
        .mask_o    (wb_mask)
    );

    // Sequencer FSM plus the instruction fields latched on accept.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            vd_q    <= '0;
            vs1_q   <= '0;
            vs2_q   <= '0;
            vl_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (instr_v_i) begin
                        vd_q    <= instr_vd_i;
                        vs1_q   <= instr_vs1_i;
                        vs2_q   <= instr_vs2_i;
                        vl_q    <= instr_vl_i;
                        state_q <= (instr_vl_i == '0) ? FIN : ISSUE;
                    end
                end
                ISSUE: begin
                    if (wb_fire && wb_last) begin
                        state_q <= FIN;
                    end else if (issue_fire && issue_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (wb_fire && wb_last) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign instr_ready_o = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == FIN);
    assign op_v_o        = (state_q == ISSUE);

    // Reads have zero latency, so operands are the register-file data as-is.
    assign r_reg0_addr_o = vs1_q;
    assign r_reg1_addr_o = vs2_q;
    assign op_a_o        = r0_data_i;
    assign op_b_o        = r1_data_i;

    assign w_reg_addr_o  = vd_q;
    assign w_data_o      = res_data_i;
    assign w_en_o        = wb_fire ? wb_mask : '0;

endmodule

// File: tb/tb_vrf_issue_seq.sv
// Directed bench for vrf_issue_seq with a register-file and lane-ALU model.
module tb_vrf_issue_seq;

    localparam int LANES = 4;
    localparam int VLEN  = 8;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int LAW   = 3;
    localparam int VLW   = 4;

    logic                  clk = 1'b0;
    logic                  reset_n_i;
    logic                  instr_v_i;
    logic                  instr_ready_o;
    logic [AW-1:0]         instr_vd_i, instr_vs1_i, instr_vs2_i;
    logic [VLW-1:0]        instr_vl_i;
    logic [AW-1:0]         r_reg0_addr_o, r_reg1_addr_o;
    logic [LANES*LAW-1:0]  r_addr_o;
    logic [LANES*DW-1:0]   r0_data_i, r1_data_i;
    logic                  op_v_o;
    logic                  op_ready_i;
    logic [LANES*DW-1:0]   op_a_o, op_b_o;
    logic [LANES-1:0]      op_mask_o;
    logic                  res_v_i;
    logic [LANES*DW-1:0]   res_data_i;
    logic [AW-1:0]         w_reg_addr_o;
    logic [LANES*LAW-1:0]  w_addr_o;
    logic [LANES*DW-1:0]   w_data_o;
    logic [LANES-1:0]      w_en_o;
    logic                  busy_o;
    logic                  done_o;

    vrf_issue_seq dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n_i),
        .instr_v_i     (instr_v_i),
        .instr_ready_o (instr_ready_o),
        .instr_vd_i    (instr_vd_i),
        .instr_vs1_i   (instr_vs1_i),
        .instr_vs2_i   (instr_vs2_i),
        .instr_vl_i    (instr_vl_i),
        .r_reg0_addr_o (r_reg0_addr_o),
        .r_reg1_addr_o (r_reg1_addr_o),
        .r_addr_o      (r_addr_o),
        .r0_data_i     (r0_data_i),
        .r1_data_i     (r1_data_i),
        .op_v_o        (op_v_o),
        .op_ready_i    (op_ready_i),
        .op_a_o        (op_a_o),
        .op_b_o        (op_b_o),
        .op_mask_o     (op_mask_o),
        .res_v_i       (res_v_i),
        .res_data_i    (res_data_i),
        .w_reg_addr_o  (w_reg_addr_o),
        .w_addr_o      (w_addr_o),
        .w_data_o      (w_data_o),
        .w_en_o        (w_en_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         vd, vs1, vs2, vl;
        int         stall, delay;
        int         exp_issues, exp_wbs;
        logic [3:0] exp_opmask, exp_wen;
        int         exp_done;
    } vec_t;

    typedef struct {
        int                  due;
        logic [LANES*DW-1:0] data;
    } res_t;

    vec_t tbl[7];
    res_t rq[$];

    logic [DW-1:0] rf [0:31][0:VLEN-1];
    logic          rf_init;

    int n_pass = 0;
    int n_total = 0;

    function automatic logic [DW-1:0] seed(input int r, input int e);
        return DW'(r * 4099 + e * 131) ^ 32'hA5C3_0000;
    endfunction

    function automatic logic [DW-1:0] alu(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a + {b[15:0], b[31:16]}) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [LANES*LAW-1:0] exp_idx(input int beat);
        logic [LANES*LAW-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) v[i*LAW +: LAW] = LAW'(beat * LANES + i);
        return v;
    endfunction

    // Register file: write port from the DUT, bulk fill on request.
    always @(posedge clk) begin
        if (rf_init) begin
            for (int r = 0; r < 32; r++)
                for (int e = 0; e < VLEN; e++) rf[r][e] <= seed(r, e);
        end else begin
            for (int i = 0; i < LANES; i++)
                if (w_en_o[i]) rf[w_reg_addr_o][w_addr_o[i*LAW +: LAW]] <= w_data_o[i*DW +: DW];
        end
    end

    // Combinational read ports.
    always_comb begin
        r0_data_i = '0;
        r1_data_i = '0;
        for (int i = 0; i < LANES; i++) begin
            r0_data_i[i*DW +: DW] = rf[r_reg0_addr_o][r_addr_o[i*LAW +: LAW]];
            r1_data_i[i*DW +: DW] = rf[r_reg1_addr_o][r_addr_o[i*LAW +: LAW]];
        end
    end

    // Results arriving with nothing in flight must never reach the write port.
    always @(negedge clk) begin
        #2;
        if (reset_n_i && res_v_i && !busy_o)
            assert (w_en_o == '0)
            else $error("FAIL stray_result_dropped: w_en=%h required 0", w_en_o);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Runs one instruction from negedge to the cycle after done. When abort_wb
    // is nonzero, returns right after that many writebacks have been observed.
    task automatic run_instr(input vec_t t, input int abort_wb);
        logic [DW-1:0]       o1[VLEN], o2[VLEN], od[VLEN];
        logic [DW-1:0]       ev;
        logic [LANES*DW-1:0] rd;
        logic [3:0]          lastmask, lastw;
        int cyc, stall_left, nissue, nwb, done_cyc;
        bit done_seen;
        for (int e = 0; e < VLEN; e++) begin
            o1[e] = rf[t.vs1][e];
            o2[e] = rf[t.vs2][e];
            od[e] = rf[t.vd][e];
        end
        lastmask = '0; lastw = '0; nissue = 0; nwb = 0; done_cyc = -1;
        done_seen = 0; stall_left = t.stall; cyc = 0;

        instr_v_i   = 1'b1;
        instr_vd_i  = AW'(t.vd);
        instr_vs1_i = AW'(t.vs1);
        instr_vs2_i = AW'(t.vs2);
        instr_vl_i  = VLW'(t.vl);
        #1;
        check("instr_ready_idle", 128'(instr_ready_o), 128'(1));
        @(posedge clk);
        @(negedge clk);
        instr_v_i = 1'b0;

        for (int k = 0; k < 60; k++) begin
            op_ready_i = (stall_left > 0) ? 1'b0 : 1'b1;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                res_v_i    = 1'b1;
                res_data_i = rq[0].data;
                void'(rq.pop_front());
            end else begin
                res_v_i    = 1'b0;
                res_data_i = '0;
            end
            #1;
            if (op_v_o) begin
                if (!op_ready_i) begin
                    check("stall_raddr_stable", 128'(r_addr_o), 128'(exp_idx(nissue)));
                    stall_left--;
                end else begin
                    check("issue_raddr", 128'(r_addr_o), 128'(exp_idx(nissue)));
                    for (int i = 0; i < LANES; i++)
                        rd[i*DW +: DW] = alu(op_a_o[i*DW +: DW], op_b_o[i*DW +: DW]);
                    rq.push_back('{due: cyc + t.delay, data: rd});
                    lastmask = op_mask_o;
                    nissue++;
                end
            end
            if (w_en_o != '0) begin
                check("w_reg_addr", 128'(w_reg_addr_o), 128'(t.vd));
                check("w_addr", 128'(w_addr_o), 128'(exp_idx(nwb)));
                lastw = w_en_o;
                nwb++;
            end
            if (done_o) begin
                done_seen = 1;
                done_cyc  = cyc;
                break;
            end
            if (abort_wb > 0 && nwb == abort_wb) break;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end

        if (abort_wb == 0) begin
            if (!done_seen) check("done_timeout", 128'(0), 128'(1));
            res_v_i    = 1'b0;
            op_ready_i = 1'b1;
            @(posedge clk);
            @(negedge clk);
            #1;
            check("done_one_cycle", 128'(done_o), 128'(0));
            check("ready_after_done", 128'(instr_ready_o), 128'(1));
            check("issue_beats", 128'(nissue), 128'(t.exp_issues));
            check("wb_beats", 128'(nwb), 128'(t.exp_wbs));
            check("op_mask_last", 128'(lastmask), 128'(t.exp_opmask));
            check("w_en_last", 128'(lastw), 128'(t.exp_wen));
            check("done_cycle", 128'(done_cyc), 128'(t.exp_done));
            for (int e = 0; e < VLEN; e++) begin
                ev = (e < t.vl) ? alu(o1[e], o2[e]) : od[e];
                check($sformatf("rf_v%0d_e%0d", t.vd, e), 128'(rf[t.vd][e]), 128'(ev));
            end
        end
    endtask

    initial begin
        logic [DW-1:0] s1[VLEN], s2[VLEN], s7[VLEN];

        tbl[0] = '{vd: 5,  vs1: 3,  vs2: 4,  vl: 8, stall: 0, delay: 2, exp_issues: 2, exp_wbs: 2,
                   exp_opmask: 4'hF,    exp_wen: 4'hF,    exp_done: 4};
        tbl[1] = '{vd: 9,  vs1: 10, vs2: 11, vl: 6, stall: 0, delay: 2, exp_issues: 2, exp_wbs: 2,
                   exp_opmask: 4'b0011, exp_wen: 4'b0011, exp_done: 4};
        tbl[2] = '{vd: 12, vs1: 1,  vs2: 2,  vl: 0, stall: 0, delay: 2, exp_issues: 0, exp_wbs: 0,
                   exp_opmask: 4'h0,    exp_wen: 4'h0,    exp_done: 0};
        tbl[3] = '{vd: 6,  vs1: 7,  vs2: 8,  vl: 8, stall: 3, delay: 2, exp_issues: 2, exp_wbs: 2,
                   exp_opmask: 4'hF,    exp_wen: 4'hF,    exp_done: 7};
        tbl[4] = '{vd: 2,  vs1: 2,  vs2: 3,  vl: 8, stall: 0, delay: 1, exp_issues: 2, exp_wbs: 2,
                   exp_opmask: 4'hF,    exp_wen: 4'hF,    exp_done: 3};
        tbl[5] = '{vd: 20, vs1: 21, vs2: 22, vl: 3, stall: 0, delay: 1, exp_issues: 1, exp_wbs: 1,
                   exp_opmask: 4'b0111, exp_wen: 4'b0111, exp_done: 2};
        tbl[6] = '{vd: 7,  vs1: 1,  vs2: 2,  vl: 5, stall: 0, delay: 1, exp_issues: 2, exp_wbs: 2,
                   exp_opmask: 4'b0001, exp_wen: 4'b0001, exp_done: 3};

        reset_n_i   = 1'b0;
        rf_init     = 1'b1;
        instr_v_i   = 1'b0;
        instr_vd_i  = '0;
        instr_vs1_i = '0;
        instr_vs2_i = '0;
        instr_vl_i  = '0;
        op_ready_i  = 1'b1;
        res_v_i     = 1'b0;
        res_data_i  = '0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_op_v", 128'(op_v_o), 128'(0));
        check("rst_w_en", 128'(w_en_o), 128'(0));
        check("rst_done", 128'(done_o), 128'(0));
        check("rst_busy", 128'(busy_o), 128'(0));
        check("rst_instr_ready", 128'(instr_ready_o), 128'(1));
        rf_init   = 1'b0;
        reset_n_i = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 6; t++) run_instr(tbl[t], 0);

        // Reset in the middle of an instruction, after one result beat.
        for (int e = 0; e < VLEN; e++) begin
            s1[e] = rf[1][e];
            s2[e] = rf[2][e];
            s7[e] = rf[7][e];
        end
        run_instr('{vd: 7, vs1: 1, vs2: 2, vl: 8, stall: 0, delay: 1, exp_issues: 2, exp_wbs: 2,
                    exp_opmask: 4'hF, exp_wen: 4'hF, exp_done: 3}, 1);
        @(posedge clk);
        @(negedge clk);
        reset_n_i  = 1'b0;
        res_v_i    = 1'b0;
        res_data_i = '0;
        rq.delete();
        #1;
        check("midrst_busy", 128'(busy_o), 128'(0));
        check("midrst_op_v", 128'(op_v_o), 128'(0));
        check("midrst_w_en", 128'(w_en_o), 128'(0));
        check("midrst_done", 128'(done_o), 128'(0));
        check("midrst_ready", 128'(instr_ready_o), 128'(1));
        @(posedge clk);
        @(negedge clk);
        reset_n_i  = 1'b1;
        res_v_i    = 1'b1;
        res_data_i = {LANES{32'hDEAD_BEEF}};
        #1;
        check("late_result_w_en", 128'(w_en_o), 128'(0));
        @(posedge clk);
        @(negedge clk);
        res_v_i    = 1'b0;
        res_data_i = '0;
        for (int e = 0; e < VLEN; e++)
            check($sformatf("midrst_v7_e%0d", e), 128'(rf[7][e]),
                  128'((e < LANES) ? alu(s1[e], s2[e]) : s7[e]));

        run_instr(tbl[6], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
